// File: rtl/pipe_ctrl_unit.sv
// Pipelined main control unit for a 5-stage MIPS-style core.
//
// Decodes the ID-stage opcode into a control bundle and carries it through the
// ID/EX, EX/MEM and MEM/WB registers together with the destination register. It
// also detects load-use and control hazards and produces the EX-stage operand
// forwarding selects.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   id_valid, id_opcode        IF/ID holds a real instruction / its opcode field
//   id_rs, id_rt, id_rd        register fields of the ID instruction
//   ex_br_taken                EX resolved a taken beq
//   stall, flush_ifid          hold PC + IF/ID / squash IF/ID this cycle
//   id_illegal, err_sticky     undefined opcode in ID / latched illegal flag
//   ex_*                       EX-stage controls and destination
//   mem_*                      MEM-stage controls and destination
//   wb_*                       WB-stage controls and destination
//   fwd_a, fwd_b               EX operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
module pipe_ctrl_unit #(
    parameter int unsigned OPW    = 6,
    parameter int unsigned RAW    = 5,
    parameter int unsigned ALUOPW = 2,
    parameter int unsigned MTRW   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [OPW-1:0]    id_opcode,
    input  logic [RAW-1:0]    id_rs,
    input  logic [RAW-1:0]    id_rt,
    input  logic [RAW-1:0]    id_rd,
    input  logic              ex_br_taken,
    output logic              stall,
    output logic              flush_ifid,
    output logic              id_illegal,
    output logic              err_sticky,
    output logic              ex_regDest,
    output logic              ex_ALUSrc,
    output logic              ex_branch,
    output logic              ex_jump,
    output logic [ALUOPW-1:0] ex_ALUOp,
    output logic [RAW-1:0]    ex_wr_reg,
    output logic              mem_MemRead,
    output logic              mem_MemWrite,
    output logic [RAW-1:0]    mem_wr_reg,
    output logic              wb_RegWrite,
    output logic [MTRW-1:0]   wb_MemtoReg,
    output logic [RAW-1:0]    wb_wr_reg,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
);

    localparam logic [OPW-1:0] OpRtype = 6'b000000;
    localparam logic [OPW-1:0] OpLw    = 6'b100011;
    localparam logic [OPW-1:0] OpSw    = 6'b101011;
    localparam logic [OPW-1:0] OpBeq   = 6'b000100;
    localparam logic [OPW-1:0] OpJ     = 6'b000010;
    localparam logic [OPW-1:0] OpAddi  = 6'b001000;
    localparam logic [OPW-1:0] OpOri   = 6'b001101;
    localparam logic [OPW-1:0] OpSlti  = 6'b001010;
    localparam logic [OPW-1:0] OpLui   = 6'b001111;

    localparam logic [ALUOPW-1:0] AluAdd = 2'b00;
    localparam logic [ALUOPW-1:0] AluSub = 2'b01;
    localparam logic [ALUOPW-1:0] AluR   = 2'b10;
    localparam logic [ALUOPW-1:0] AluImm = 2'b11;

    localparam logic [MTRW-1:0] MtrMem = 2'b01;
    localparam logic [MTRW-1:0] MtrLui = 2'b10;

    typedef struct packed {
        logic              reg_dest;
        logic              reg_write;
        logic              alu_src;
        logic [ALUOPW-1:0] alu_op;
        logic              mem_read;
        logic              mem_write;
        logic [MTRW-1:0]   mem_to_reg;
        logic              branch;
        logic              jump;
    } ctrl_t;

    ctrl_t          dec;
    logic           legal;
    logic           uses_rt;
    logic [RAW-1:0] id_wr_reg;
    logic           load_use;
    logic           bubble;

    // ID/EX
    ctrl_t          ex_ctrl_q, ex_ctrl_d;
    logic [RAW-1:0] ex_wr_reg_q, ex_wr_reg_d;
    logic [RAW-1:0] ex_rs_q, ex_rs_d;
    logic [RAW-1:0] ex_rt_q, ex_rt_d;
    // EX/MEM
    logic            mem_mem_read_q, mem_mem_write_q, mem_reg_write_q;
    logic [MTRW-1:0] mem_mem_to_reg_q;
    logic [RAW-1:0]  mem_wr_reg_q;
    // MEM/WB
    logic            wb_reg_write_q;
    logic [MTRW-1:0] wb_mem_to_reg_q;
    logic [RAW-1:0]  wb_wr_reg_q;
    logic            err_sticky_q, err_sticky_d;

    // Decode. uses_rt marks opcodes that read rt as a source operand.
    always_comb begin
        dec     = '0;
        legal   = 1'b1;
        uses_rt = 1'b0;
        case (id_opcode)
            OpRtype: begin
                dec.reg_dest  = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_op    = AluR;
                uses_rt       = 1'b1;
            end
            OpLw: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.alu_op     = AluAdd;
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = MtrMem;
            end
            OpSw: begin
                dec.alu_src   = 1'b1;
                dec.alu_op    = AluAdd;
                dec.mem_write = 1'b1;
                uses_rt       = 1'b1;
            end
            OpBeq: begin
                dec.alu_op = AluSub;
                dec.branch = 1'b1;
                uses_rt    = 1'b1;
            end
            OpJ: begin
                dec.jump = 1'b1;
            end
            OpAddi, OpOri, OpSlti: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = AluImm;
            end
            OpLui: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.alu_op     = AluAdd;
                dec.mem_to_reg = MtrLui;
            end
            default: legal = 1'b0;
        endcase
    end

    assign id_illegal = id_valid & ~legal;
    assign id_wr_reg  = dec.reg_dest ? id_rd : id_rt;

    // A load in EX whose result the ID instruction needs forces a one-cycle hold.
    assign load_use = ex_ctrl_q.mem_read && (ex_wr_reg_q != '0) &&
                      ((ex_wr_reg_q == id_rs) || ((ex_wr_reg_q == id_rt) && uses_rt));

    // A taken branch squashes the ID instruction anyway, so it overrides the stall.
    assign stall      = load_use & ~ex_br_taken;
    assign flush_ifid = ex_br_taken | (id_valid & (id_opcode == OpJ));
    assign bubble     = ~id_valid | id_illegal | stall | ex_br_taken;

    always_comb begin
        ex_ctrl_d    = '0;
        ex_wr_reg_d  = '0;
        ex_rs_d      = '0;
        ex_rt_d      = '0;
        if (!bubble) begin
            ex_ctrl_d   = dec;
            ex_wr_reg_d = id_wr_reg;
            ex_rs_d     = id_rs;
            ex_rt_d     = id_rt;
        end
    end

    assign err_sticky_d = err_sticky_q | id_illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ctrl_q        <= '0;
            ex_wr_reg_q      <= '0;
            ex_rs_q          <= '0;
            ex_rt_q          <= '0;
            mem_mem_read_q   <= 1'b0;
            mem_mem_write_q  <= 1'b0;
            mem_reg_write_q  <= 1'b0;
            mem_mem_to_reg_q <= '0;
            mem_wr_reg_q     <= '0;
            wb_reg_write_q   <= 1'b0;
            wb_mem_to_reg_q  <= '0;
            wb_wr_reg_q      <= '0;
            err_sticky_q     <= 1'b0;
        end else begin
            ex_ctrl_q        <= ex_ctrl_d;
            ex_wr_reg_q      <= ex_wr_reg_d;
            ex_rs_q          <= ex_rs_d;
            ex_rt_q          <= ex_rt_d;
            mem_mem_read_q   <= ex_ctrl_q.mem_read;
            mem_mem_write_q  <= ex_ctrl_q.mem_write;
            mem_reg_write_q  <= ex_ctrl_q.reg_write;
            mem_mem_to_reg_q <= ex_ctrl_q.mem_to_reg;
            mem_wr_reg_q     <= ex_wr_reg_q;
            wb_reg_write_q   <= mem_reg_write_q;
            wb_mem_to_reg_q  <= mem_mem_to_reg_q;
            wb_wr_reg_q      <= mem_wr_reg_q;
            err_sticky_q     <= err_sticky_d;
        end
    end

    // Younger result (EX/MEM) wins; r0 is hardwired and never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [RAW-1:0] src);
        logic [1:0] sel;
        sel = 2'b00;
        if (mem_reg_write_q && (mem_wr_reg_q != '0) && (mem_wr_reg_q == src)) begin
            sel = 2'b10;
        end else if (wb_reg_write_q && (wb_wr_reg_q != '0) && (wb_wr_reg_q == src)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    assign fwd_a = fwd_sel(ex_rs_q);
    assign fwd_b = fwd_sel(ex_rt_q);

    assign ex_regDest   = ex_ctrl_q.reg_dest;
    assign ex_ALUSrc    = ex_ctrl_q.alu_src;
    assign ex_branch    = ex_ctrl_q.branch;
    assign ex_jump      = ex_ctrl_q.jump;
    assign ex_ALUOp     = ex_ctrl_q.alu_op;
    assign ex_wr_reg    = ex_wr_reg_q;
    assign mem_MemRead  = mem_mem_read_q;
    assign mem_MemWrite = mem_mem_write_q;
    assign mem_wr_reg   = mem_wr_reg_q;
    assign wb_RegWrite  = wb_reg_write_q;
    assign wb_MemtoReg  = wb_mem_to_reg_q;
    assign wb_wr_reg    = wb_wr_reg_q;
    assign err_sticky   = err_sticky_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: decode table vectors, hand-written
// hazard/reset sequences and a randomized run against a stage-list model.
module tb_pipe_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [5:0] id_opcode = '0;
    logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic       ex_br_taken = 1'b0;
    logic       stall, flush_ifid, id_illegal, err_sticky;
    logic       ex_regDest, ex_ALUSrc, ex_branch, ex_jump;
    logic [1:0] ex_ALUOp;
    logic [4:0] ex_wr_reg;
    logic       mem_MemRead, mem_MemWrite;
    logic [4:0] mem_wr_reg;
    logic       wb_RegWrite;
    logic [1:0] wb_MemtoReg;
    logic [4:0] wb_wr_reg;
    logic [1:0] fwd_a, fwd_b;

    pipe_ctrl_unit dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_br_taken(ex_br_taken),
        .stall(stall), .flush_ifid(flush_ifid), .id_illegal(id_illegal),
        .err_sticky(err_sticky), .ex_regDest(ex_regDest), .ex_ALUSrc(ex_ALUSrc),
        .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_ALUOp(ex_ALUOp),
        .ex_wr_reg(ex_wr_reg), .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
        .mem_wr_reg(mem_wr_reg), .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg),
        .wb_wr_reg(wb_wr_reg), .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic br);
        id_valid = v; id_opcode = op; id_rs = rs; id_rt = rt; id_rd = rd; ex_br_taken = br;
    endtask

    task automatic do_reset();
        drive(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    function automatic logic [63:0] all_outs();
        return {30'd0, stall, flush_ifid, id_illegal, err_sticky, ex_regDest, ex_ALUSrc,
                ex_branch, ex_jump, ex_ALUOp, ex_wr_reg, mem_MemRead, mem_MemWrite,
                mem_wr_reg, wb_RegWrite, wb_MemtoReg, wb_wr_reg, fwd_a, fwd_b};
    endfunction

    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
    localparam logic [5:0] J = 6'b000010, ADDI = 6'b001000, ORI = 6'b001101;
    localparam logic [5:0] SLTI = 6'b001010, LUI = 6'b001111, ILL = 6'b111111;

    // ---------------- table vectors ----------------
    typedef struct {
        logic [5:0] op;
        logic       ill;
        logic       flush;
        logic [3:0] ex_bits;   // regDest, ALUSrc, branch, jump
        logic [1:0] aluop;
        logic [4:0] ex_wr;
        logic [1:0] mem_bits;  // MemRead, MemWrite
        logic       rw;
        logic [1:0] mtr;
    } vec_t;

    vec_t vecs[10];

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       rdst, rw, asrc;
        logic [1:0] aop;
        logic       mr, mw;
        logic [1:0] mtr;
        logic       br, jp;
        logic [4:0] wr, rs, rt;
    } stg_t;

    stg_t pipe[3];  // 0 = EX, 1 = MEM, 2 = WB
    logic m_err;

    function automatic logic m_legal(input logic [5:0] op);
        return op inside {R, LW, SW, BEQ, J, ADDI, ORI, SLTI, LUI};
    endfunction

    function automatic stg_t m_dec(input logic [5:0] op, input logic [4:0] rs,
                                   input logic [4:0] rt, input logic [4:0] rd);
        stg_t s;
        s = '0;
        case (op)
            R:    begin s.rdst = 1; s.rw = 1; s.aop = 2'b10; end
            LW:   begin s.rw = 1; s.asrc = 1; s.mr = 1; s.mtr = 2'b01; end
            SW:   begin s.asrc = 1; s.mw = 1; end
            BEQ:  begin s.aop = 2'b01; s.br = 1; end
            J:    begin s.jp = 1; end
            ADDI, ORI, SLTI: begin s.rw = 1; s.asrc = 1; s.aop = 2'b11; end
            LUI:  begin s.rw = 1; s.asrc = 1; s.mtr = 2'b10; end
            default: s = '0;
        endcase
        s.wr = s.rdst ? rd : rt;
        s.rs = rs;
        s.rt = rt;
        return s;
    endfunction

    // Scan older stages youngest-first for a writer of src.
    function automatic logic [1:0] m_fwd(input logic [4:0] src);
        if (src == 0) return 2'b00;
        for (int k = 1; k <= 2; k++) begin
            if (pipe[k].rw && pipe[k].wr == src) return (k == 1) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    initial begin
        vecs[0] = '{R,    0, 0, 4'b1000, 2'b10, 5'd3, 2'b00, 1, 2'b00};
        vecs[1] = '{LW,   0, 0, 4'b0100, 2'b00, 5'd2, 2'b10, 1, 2'b01};
        vecs[2] = '{SW,   0, 0, 4'b0100, 2'b00, 5'd2, 2'b01, 0, 2'b00};
        vecs[3] = '{BEQ,  0, 0, 4'b0010, 2'b01, 5'd2, 2'b00, 0, 2'b00};
        vecs[4] = '{J,    0, 1, 4'b0001, 2'b00, 5'd2, 2'b00, 0, 2'b00};
        vecs[5] = '{ADDI, 0, 0, 4'b0100, 2'b11, 5'd2, 2'b00, 1, 2'b00};
        vecs[6] = '{ORI,  0, 0, 4'b0100, 2'b11, 5'd2, 2'b00, 1, 2'b00};
        vecs[7] = '{SLTI, 0, 0, 4'b0100, 2'b11, 5'd2, 2'b00, 1, 2'b00};
        vecs[8] = '{LUI,  0, 0, 4'b0100, 2'b00, 5'd2, 2'b00, 1, 2'b10};
        vecs[9] = '{ILL,  1, 0, 4'b0000, 2'b00, 5'd0, 2'b00, 0, 2'b00};

        do_reset();
        chk("reset_outputs", all_outs(), 64'd0);

        // Table: each opcode walked alone through EX, MEM, WB.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, vecs[i].op, 5'd1, 5'd2, 5'd3, 1'b0);
            #1;
            chk("tbl_illegal", id_illegal, vecs[i].ill);
            chk("tbl_flush", flush_ifid, vecs[i].flush);
            step();
            drive(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
            chk("tbl_ex_bits", {ex_regDest, ex_ALUSrc, ex_branch, ex_jump}, vecs[i].ex_bits);
            chk("tbl_ex_aluop", ex_ALUOp, vecs[i].aluop);
            chk("tbl_ex_wr", ex_wr_reg, vecs[i].ex_wr);
            step();
            chk("tbl_mem_bits", {mem_MemRead, mem_MemWrite}, vecs[i].mem_bits);
            chk("tbl_mem_wr", mem_wr_reg, vecs[i].ex_wr);
            step();
            chk("tbl_wb", {wb_RegWrite, wb_MemtoReg, wb_wr_reg}, {vecs[i].rw, vecs[i].mtr,
                                                                   vecs[i].ex_wr});
        end
        chk("tbl_err_sticky", err_sticky, 1'b1);

        // add r3 <- r1,r2 latency through the pipe.
        do_reset();
        drive(1'b1, R, 5'd1, 5'd2, 5'd3, 1'b0);
        step();
        drive(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("add_ex", {ex_regDest, ex_ALUOp, ex_wr_reg}, {1'b1, 2'b10, 5'd3});
        step();
        step();
        chk("add_wb", {wb_RegWrite, wb_MemtoReg, wb_wr_reg}, {1'b1, 2'b00, 5'd3});

        // lw r5 then add using r5: one stall, bubble, then MEM/WB forwarding.
        do_reset();
        drive(1'b1, LW, 5'd0, 5'd5, 5'd0, 1'b0);
        step();
        drive(1'b1, R, 5'd5, 5'd6, 5'd7, 1'b0);
        #1;
        chk("lu_stall", stall, 1'b1);
        step();
        chk("lu_bubble", {ex_regDest, ex_ALUOp, ex_wr_reg}, 8'd0);
        chk("lu_stall_drop", stall, 1'b0);
        step();
        drive(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("lu_add_ex", {ex_regDest, ex_wr_reg}, {1'b1, 5'd7});
        chk("lu_fwd_a", fwd_a, 2'b01);
        chk("lu_fwd_b", fwd_b, 2'b00);

        // Back-to-back dependent R-types: EX/MEM forwarding on both operands.
        do_reset();
        drive(1'b1, R, 5'd1, 5'd2, 5'd4, 1'b0);
        step();
        drive(1'b1, R, 5'd4, 5'd4, 5'd5, 1'b0);
        step();
        drive(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("fwd_exmem", {fwd_a, fwd_b}, 4'b1010);
        // Same with r0 destination: never forwarded.
        do_reset();
        drive(1'b1, R, 5'd1, 5'd2, 5'd0, 1'b0);
        step();
        drive(1'b1, R, 5'd0, 5'd0, 5'd5, 1'b0);
        step();
        drive(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("fwd_r0", {fwd_a, fwd_b}, 4'b0000);

        // Taken branch overrides a load-use stall.
        do_reset();
        drive(1'b1, LW, 5'd0, 5'd5, 5'd0, 1'b0);
        step();
        drive(1'b1, R, 5'd5, 5'd6, 5'd7, 1'b1);
        #1;
        chk("br_stall", stall, 1'b0);
        chk("br_flush", flush_ifid, 1'b1);
        step();
        drive(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("br_bubble", {ex_regDest, ex_ALUSrc, ex_ALUOp, ex_wr_reg}, 9'd0);

        // Illegal opcode: bubble, sticky error held until reset.
        do_reset();
        drive(1'b1, ILL, 5'd1, 5'd2, 5'd3, 1'b0);
        #1;
        chk("ill_flag", id_illegal, 1'b1);
        chk("ill_sticky_pre", err_sticky, 1'b0);
        step();
        drive(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("ill_bubble", {ex_ALUSrc, ex_wr_reg}, 6'd0);
        chk("ill_sticky_set", err_sticky, 1'b1);
        step(); step(); step();
        chk("ill_sticky_hold", err_sticky, 1'b1);
        do_reset();
        chk("ill_sticky_clr", err_sticky, 1'b0);

        // Async reset mid-cycle discards an in-flight lui.
        do_reset();
        drive(1'b1, LUI, 5'd0, 5'd7, 5'd0, 1'b0);
        step();
        drive(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        #2;
        chk("lui_in_ex", {ex_ALUSrc, ex_wr_reg}, {1'b1, 5'd7});
        rst_n = 1'b0;
        #1;
        chk("async_reset", all_outs(), 64'd0);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("lui_discarded", wb_RegWrite, 1'b0);
        end

        // Randomized run against the model.
        do_reset();
        for (int k = 0; k < 3; k++) pipe[k] = '0;
        m_err = 1'b0;
        for (int n = 0; n < 400; n++) begin
            logic [5:0] op;
            logic       v, br, ill, st, fl, uses_rt;
            logic [4:0] rs, rt, rd;
            case ($urandom_range(0, 11))
                0: op = R;    1: op = LW;   2: op = SW;   3: op = BEQ;
                4: op = J;    5: op = ADDI; 6: op = ORI;  7: op = SLTI;
                8: op = LUI;  9: op = LW;   10: op = R;
                default: op = 6'($urandom_range(0, 63));
            endcase
            v  = ($urandom_range(0, 99) < 85);
            br = ($urandom_range(0, 99) < 10);
            rs = 5'($urandom_range(0, 3));
            rt = 5'($urandom_range(0, 3));
            rd = 5'($urandom_range(0, 3));
            drive(v, op, rs, rt, rd, br);
            #1;
            ill     = v && !m_legal(op);
            uses_rt = op inside {R, SW, BEQ};
            st = pipe[0].mr && pipe[0].wr != 0 &&
                 (pipe[0].wr == rs || (pipe[0].wr == rt && uses_rt)) && !br;
            fl = br || (v && op == J);
            chk("rnd_hazard", {stall, flush_ifid, id_illegal, err_sticky},
                {st, fl, ill, m_err});
            chk("rnd_ex", {ex_regDest, ex_ALUSrc, ex_branch, ex_jump, ex_ALUOp, ex_wr_reg},
                {pipe[0].rdst, pipe[0].asrc, pipe[0].br, pipe[0].jp, pipe[0].aop, pipe[0].wr});
            chk("rnd_mem", {mem_MemRead, mem_MemWrite, mem_wr_reg},
                {pipe[1].mr, pipe[1].mw, pipe[1].wr});
            chk("rnd_wb", {wb_RegWrite, wb_MemtoReg, wb_wr_reg},
                {pipe[2].rw, pipe[2].mtr, pipe[2].wr});
            chk("rnd_fwd", {fwd_a, fwd_b}, {m_fwd(pipe[0].rs), m_fwd(pipe[0].rt)});
            step();
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = (!v || ill || st || br) ? '0 : m_dec(op, rs, rt, rd);
            m_err = m_err | ill;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Pipelined successor to the single-cycle main control decoder.
- Decodes the ID-stage opcode into a control bundle, carries it through ID/EX, EX/MEM and MEM/WB registers, and computes the destination register.
- Detects load-use hazards (stall) and control hazards (flush); produces EX-stage forwarding selects.
- Sits between the IF/ID register and the EX/MEM/WB datapath of the 5-stage processor.

Parameters:
- OPW, 6, opcode width
- RAW, 5, register address width
- ALUOPW, 2, ALUOp width
- MTRW, 2, MemtoReg select width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  IF/ID holds a real instruction
- id_opcode  in  OPW  instruction[31:26]
- id_rs, id_rt, id_rd  in  RAW each  source/dest fields
- ex_br_taken  in  1  EX resolved a taken beq (ex_branch & zero)
- stall  out  1  hold PC and IF/ID this cycle
- flush_ifid  out  1  squash IF/ID this cycle
- id_illegal  out  1  combinational: valid undefined opcode in ID
- err_sticky  out  1  set by any id_illegal; cleared only by reset
- ex_regDest, ex_ALUSrc, ex_branch, ex_jump  out  1 each
- ex_ALUOp  out  ALUOPW
- ex_wr_reg  out  RAW
- mem_MemRead, mem_MemWrite  out  1 each
- mem_wr_reg  out  RAW
- wb_RegWrite  out  1
- wb_MemtoReg  out  MTRW
- wb_wr_reg  out  RAW
- fwd_a, fwd_b  out  2  operand forwarding select for EX rs/rt: 00 regfile, 10 EX/MEM, 01 MEM/WB

Behaviour:
- Reset (async, rst_n=0):
  - All stage registers, the internal ex_rs/ex_rt copies and err_sticky clear to 0.
  - Every registered output is 0, i.e. all stages hold bubbles.
- Decode table (combinational, ID); fields are regDest, RegWrite, ALUSrc, ALUOp, MemRead, MemWrite, MemtoReg, branch, jump; unlisted fields are 0:
  - R-type 000000: regDest=1, RegWrite=1, ALUOp=10.
  - lw 100011: RegWrite=1, ALUSrc=1, ALUOp=00, MemRead=1, MemtoReg=01.
  - sw 101011: ALUSrc=1, ALUOp=00, MemWrite=1.
  - beq 000100: ALUOp=01, branch=1, MemWrite=0.
  - j 000010: jump=1.
  - addi 001000, ori 001101, slti 001010: RegWrite=1, ALUSrc=1, ALUOp=11.
  - lui 001111: RegWrite=1, ALUSrc=1, ALUOp=00, MemtoReg=10.
  - Any other opcode: all-zero bundle; id_illegal=1 when id_valid=1.
- Destination: wr_reg = regDest ? id_rd : id_rt, computed in ID and registered with the bundle.
- Pipeline:
  - One-cycle advance per stage: ID→EX→MEM→WB.
  - EX/MEM and MEM/WB always advance; they have no enable.
- Bubble into ID/EX (all-zero bundle, wr_reg=0) when any of: id_valid=0, id_illegal, stall, or ex_br_taken.
- Load-use stall, combinational:
  - stall=1 when ex_MemRead=1, ex_wr_reg≠0, and (ex_wr_reg==id_rs, or ex_wr_reg==id_rt with the ID opcode R-type, sw or beq).
  - Lasts exactly one cycle; the load moves to MEM and stall drops.
- Control flush:
  - flush_ifid=1 when ex_br_taken=1, or when the ID instruction is a valid j.
  - A jump does not bubble its own ID/EX slot; it proceeds as a no-write op.
- Priority: ex_br_taken overrides stall. When both hold, stall=0, flush_ifid=1, and ID/EX takes a bubble.
- Forwarding for fwd_a (fwd_b is identical on ex_rt):
  - 10 if mem_RegWrite=1, mem_wr_reg≠0 and mem_wr_reg==ex_rs.
  - Otherwise 01 if wb_RegWrite=1, wb_wr_reg≠0 and wb_wr_reg==ex_rs.
  - Otherwise 00.
  - EX/MEM wins over MEM/WB. Register 0 is never forwarded.
- err_sticky:
  - Registered; sets on the cycle after id_illegal=1.
  - Holds until rst_n=0.
- Reset mid-operation: outputs go to 0 immediately (asynchronous), and in-flight instructions are discarded.

Test Plan:
- Reset, then R-type add (rs=1, rt=2, rd=3) with id_valid=1 → next edge: ex_regDest=1, ex_ALUOp=10, ex_wr_reg=3. Two edges later: wb_RegWrite=1, wb_MemtoReg=00, wb_wr_reg=3.
- lw rt=5 followed by add rs=5 → stall=1 and a bubble in ID/EX for exactly one cycle. Next cycle: add enters EX with fwd_a=01.
- add rd=4, then sub rs=4, rt=4 back to back → with the sub in EX: fwd_a=10 and fwd_b=10. Same case with rd=0 → fwd_a=fwd_b=00.
- beq in EX with ex_br_taken=1 while a load-use condition is present in ID → stall=0, flush_ifid=1, ID/EX bubble. beq never asserts mem_MemWrite.
- Opcode 111111 with id_valid=1 → id_illegal=1, bubble issued, err_sticky=1 next edge and stays set until rst_n pulses low.
- lui rt=7 in flight, then rst_n=0 asynchronously mid-cycle → all outputs 0 before the next clock edge. After release, wb_RegWrite never rises for the discarded lui.
